video_scan_gen: RTL and testbench

//  Raster scan generator: drives pixel coordinates gr_x/gr_y and active-video enable en

---
 rtl/video_scan_pkg.sv | 30 +++
 rtl/scan_axis_counter.sv | 86 ++++++++
 rtl/video_scan_gen.sv | 99 +++++++++
 tb/tb_video_scan_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/video_scan_pkg.sv
// rtl/video_scan_pkg.sv - shared types, widths and timing helpers for the raster scan generator
package video_scan_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // Total positions along one axis (line length or frame height).
    function automatic int axis_total(input int len_active, input int len_fp,
                                      input int len_sync, input int len_bp);
        return len_active + len_fp + len_sync + len_bp;
    endfunction

    // Phase order along an axis, ignoring phase lengths.
    function automatic phase_t phase_succ(input phase_t p);
        case (p)
            PH_ACTIVE: return PH_FRONT;
            PH_FRONT:  return PH_SYNC;
            PH_SYNC:   return PH_BACK;
            default:   return PH_ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// rtl/scan_axis_counter.sv - one raster axis: position counter, phase FSM and wrap strobe
module scan_axis_counter
    import video_scan_pkg::*;
#(
    parameter int LEN_ACTIVE = 640,
    parameter int LEN_FP     = 16,
    parameter int LEN_SYNC   = 96,
    parameter int LEN_BP     = 48,
    parameter int W          = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         step,
    output logic [W-1:0] count,
    output phase_t       phase,
    output logic         wrap
);

    localparam int TOTAL = axis_total(LEN_ACTIVE, LEN_FP, LEN_SYNC, LEN_BP);

    logic [W-1:0] count_next;
    phase_t       phase_next;

    function automatic int phase_len(input phase_t p);
        case (p)
            PH_ACTIVE: return LEN_ACTIVE;
            PH_FRONT:  return LEN_FP;
            PH_SYNC:   return LEN_SYNC;
            default:   return LEN_BP;
        endcase
    endfunction

    // Last count value belonging to a phase; the phase is left after this position.
    function automatic logic [W-1:0] phase_last(input phase_t p);
        case (p)
            PH_ACTIVE: return W'(LEN_ACTIVE - 1);
            PH_FRONT:  return W'(LEN_ACTIVE + LEN_FP - 1);
            PH_SYNC:   return W'(LEN_ACTIVE + LEN_FP + LEN_SYNC - 1);
            default:   return W'(TOTAL - 1);
        endcase
    endfunction

    // Following phase, stepping over zero-length phases so they never appear.
    function automatic phase_t phase_after(input phase_t p);
        phase_t q;
        q = phase_succ(p);
        for (int i = 0; i < 3; i++) begin
            if (phase_len(q) == 0) q = phase_succ(q);
        end
        return q;
    endfunction

    // Next-state logic: clear wins, otherwise advance on step and leave a phase at its last position.
    always_comb begin
        count_next = count;
        phase_next = phase;
        wrap       = 1'b0;
        if (clear) begin
            count_next = '0;
            phase_next = PH_ACTIVE;
        end else if (step) begin
            if (count == W'(TOTAL - 1)) begin
                count_next = '0;
                wrap       = 1'b1;
            end else begin
                count_next = count + W'(1);
            end
            if (count == phase_last(phase)) begin
                phase_next = phase_after(phase);
            end
        end
    end

    // Counter and phase state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else begin
            count <= count_next;
            phase <= phase_next;
        end
    end

endmodule

// File: rtl/video_scan_gen.sv
// rtl/video_scan_gen.sv - raster scan generator with registered coordinates and syncs (option: VIDEO_SCAN_FRAME_PULSE_EN)
module video_scan_gen
    import video_scan_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_ce,
    input  logic           run,
    output logic [X_W-1:0] gr_x,
    output logic [Y_W-1:0] gr_y,
    output logic           en,
    output logic           hsync,
    output logic           vsync
`ifdef VIDEO_SCAN_FRAME_PULSE_EN
    ,
    output logic           frame_start,
    output logic           line_start
`endif
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 2048 || V_TOTAL > 1024 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_timing
        $error("video_scan_gen: timing parameters out of range");
    end

    logic [X_W-1:0] h_count;
    logic [Y_W-1:0] v_count;
    phase_t         h_phase;
    phase_t         v_phase;
    logic           h_wrap;
    logic           unused_v_wrap;

    scan_axis_counter #(
        .LEN_ACTIVE(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP), .W(X_W)
    ) u_h (
        .clk(clk), .rst(reset), .clear(~run), .step(pix_ce),
        .count(h_count), .phase(h_phase), .wrap(h_wrap)
    );

    scan_axis_counter #(
        .LEN_ACTIVE(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP), .W(Y_W)
    ) u_v (
        .clk(clk), .rst(reset), .clear(~run), .step(h_wrap),
        .count(v_count), .phase(v_phase), .wrap(unused_v_wrap)
    );

    // Output decode registers: present the current counter position one clk later, all aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gr_x  <= '0;
            gr_y  <= '0;
            en    <= 1'b0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
        end else if (!run) begin
            gr_x  <= '0;
            gr_y  <= '0;
            en    <= 1'b0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
        end else if (pix_ce) begin
            gr_x  <= h_count;
            gr_y  <= v_count;
            en    <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            hsync <= (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync <= (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
        end
    end

`ifdef VIDEO_SCAN_FRAME_PULSE_EN
    // Single-clk start pulses, raised only on the edge that presents x=0 (and y=0 for frames).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (!run) begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            frame_start <= pix_ce && (h_count == '0) && (v_count == '0);
            line_start  <= pix_ce && (h_count == '0);
        end
    end
`endif

endmodule

// File: tb/tb_video_scan_gen.sv
// tb/tb_video_scan_gen.sv - randomized self-checking bench for video_scan_gen against a coordinate model
module tb_video_scan_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_ce = 1'b0;
    logic run = 1'b0;

    always #5 clk = ~clk;

    // Three builds: small timing, zero-length porches with inverted polarities, and default timing.
    int cfg_ha[3] = '{8, 5, 640};
    int cfg_hf[3] = '{2, 0, 16};
    int cfg_hs[3] = '{3, 2, 96};
    int cfg_hb[3] = '{2, 0, 48};
    int cfg_va[3] = '{5, 3, 480};
    int cfg_vf[3] = '{1, 0, 10};
    int cfg_vs[3] = '{2, 1, 2};
    int cfg_vb[3] = '{1, 0, 33};
    int cfg_hp[3] = '{0, 1, 0};
    int cfg_vp[3] = '{1, 0, 0};

    logic [10:0] ox [3];
    logic [9:0]  oy [3];
    logic        oen[3];
    logic        ohs[3];
    logic        ovs[3];
    logic        ofs[3];
    logic        ols[3];

    video_scan_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .run(run),
        .gr_x(ox[0]), .gr_y(oy[0]), .en(oen[0]), .hsync(ohs[0]), .vsync(ovs[0])
`ifdef VIDEO_SCAN_FRAME_PULSE_EN
        , .frame_start(ofs[0]), .line_start(ols[0])
`endif
    );

    video_scan_gen #(
        .H_ACTIVE(5), .H_FP(0), .H_SYNC(2), .H_BP(0),
        .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(0),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .run(run),
        .gr_x(ox[1]), .gr_y(oy[1]), .en(oen[1]), .hsync(ohs[1]), .vsync(ovs[1])
`ifdef VIDEO_SCAN_FRAME_PULSE_EN
        , .frame_start(ofs[1]), .line_start(ols[1])
`endif
    );

    video_scan_gen dut_c (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .run(run),
        .gr_x(ox[2]), .gr_y(oy[2]), .en(oen[2]), .hsync(ohs[2]), .vsync(ovs[2])
`ifdef VIDEO_SCAN_FRAME_PULSE_EN
        , .frame_start(ofs[2]), .line_start(ols[2])
`endif
    );

`ifndef VIDEO_SCAN_FRAME_PULSE_EN
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            ofs[d] = 1'b0;
            ols[d] = 1'b0;
        end
    end
`endif

    int checks = 0;
    int failures = 0;

    int mh[3], mv[3];
    int ex[3], ey[3], een[3], ehs[3], evs[3], efs[3], els[3];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            mh[d] = 0; mv[d] = 0;
            ex[d] = 0; ey[d] = 0; een[d] = 0;
            ehs[d] = 1 - cfg_hp[d]; evs[d] = 1 - cfg_vp[d];
            efs[d] = 0; els[d] = 0;
        end
    endtask

    // One clk edge of the reference: report the current position, then advance along the raster.
    task automatic model_edge();
        int hlo, hhi, vlo, vhi, ht, vt;
        if (!run) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            efs[d] = 0; els[d] = 0;
            if (pix_ce) begin
                hlo = cfg_ha[d] + cfg_hf[d];
                hhi = hlo + cfg_hs[d];
                vlo = cfg_va[d] + cfg_vf[d];
                vhi = vlo + cfg_vs[d];
                ht  = hhi + cfg_hb[d];
                vt  = vhi + cfg_vb[d];
                ex[d]  = mh[d];
                ey[d]  = mv[d];
                een[d] = (mh[d] < cfg_ha[d] && mv[d] < cfg_va[d]) ? 1 : 0;
                ehs[d] = (mh[d] >= hlo && mh[d] < hhi) ? cfg_hp[d] : 1 - cfg_hp[d];
                evs[d] = (mv[d] >= vlo && mv[d] < vhi) ? cfg_vp[d] : 1 - cfg_vp[d];
                els[d] = (mh[d] == 0) ? 1 : 0;
                efs[d] = (mh[d] == 0 && mv[d] == 0) ? 1 : 0;
                mh[d]++;
                if (mh[d] == ht) begin
                    mh[d] = 0;
                    mv[d]++;
                    if (mv[d] == vt) mv[d] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_gr_x", d), int'(ox[d]), ex[d]);
            check($sformatf("d%0d_gr_y", d), int'(oy[d]), ey[d]);
            check($sformatf("d%0d_en", d), int'(oen[d]), een[d]);
            check($sformatf("d%0d_hsync", d), int'(ohs[d]), ehs[d]);
            check($sformatf("d%0d_vsync", d), int'(ovs[d]), evs[d]);
`ifdef VIDEO_SCAN_FRAME_PULSE_EN
            check($sformatf("d%0d_frame_start", d), int'(ofs[d]), efs[d]);
            check($sformatf("d%0d_line_start", d), int'(ols[d]), els[d]);
`endif
        end
    endtask

    task automatic one_cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    int en_count_a;
    int hs_count_c;
    int fs_count_a;
    int ls_count_a;

    initial begin
        model_clear();
        #12;
        compare_all();
        reset = 1'b0;
        #10;
        compare_all();

        // Free-running scan: one full small frame and one full default line.
        run = 1'b1;
        pix_ce = 1'b1;
        en_count_a = 0; hs_count_c = 0; fs_count_a = 0; ls_count_a = 0;
        for (int c = 1; c <= 1700; c++) begin
            one_cycle();
            if (c <= 135 && oen[0]) en_count_a++;
            if (c <= 135 && ofs[0]) fs_count_a++;
            if (c <= 135 && ols[0]) ls_count_a++;
            if (c <= 800 && !ohs[2]) hs_count_c++;
        end
        check("a_en_per_frame", en_count_a, 40);
        check("c_hsync_low_per_line", hs_count_c, 96);
`ifdef VIDEO_SCAN_FRAME_PULSE_EN
        check("a_frame_pulses", fs_count_a, 1);
        check("a_line_pulses", ls_count_a, 9);
`endif

        // Random pixel enable and occasional run drops.
        for (int c = 0; c < 3000; c++) begin
            pix_ce = ($urandom_range(0, 3) != 0);
            run    = ($urandom_range(0, 60) != 0);
            one_cycle();
        end

        // Asynchronous reset between edges must act without a clock edge.
        run = 1'b1;
        pix_ce = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(3, 40)) one_cycle();
            #2;
            reset = 1'b1;
            #1;
            model_clear();
            compare_all();
            #1;
            reset = 1'b0;
        end
        repeat (200) one_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
